// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding tracker: a shift chain of pending register writes, one entry
// per post-decode stage, resolving per-operand stall or forward-stage select.
module pipe_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int REGW       = 5,
  parameter int NSRC       = 2,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic                 issue_load,
  input  logic [REGW-1:0]      issue_wreg,
  input  logic [NSRC*REGW-1:0] src_reg,
  input  logic [NSRC-1:0]      src_used,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 stall,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [31:0]          stall_cnt
);

  if (DEPTH < 2 || ALU_READY < 1 || ALU_READY > LOAD_READY || LOAD_READY > DEPTH) begin : g_bad_params
    $fatal(1, "pipe_scoreboard: need DEPTH>=2 and 1 <= ALU_READY <= LOAD_READY <= DEPTH");
  end

  logic [DEPTH:1]  r_valid;
  logic [DEPTH:1]  r_we;
  logic [DEPTH:1]  r_load;
  logic [REGW-1:0] r_wreg [1:DEPTH];
  logic [31:0]     r_stall_cnt;

  logic [DEPTH:1]  w_pend;
  logic [NSRC-1:0] w_found;
  logic [NSRC-1:0] w_op_stall;

  always_comb begin
    w_pend = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      w_pend[k] = r_valid[k] && r_we[k] && (r_wreg[k] != '0);
    end
  end

  // Stages are scanned youngest first; the found flag masks any older match.
  always_comb begin
    w_found    = '0;
    w_op_stall = '0;
    fwd_sel    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (!w_found[i] && w_pend[k] && src_used[i] &&
            (src_reg[i*REGW +: REGW] != '0) &&
            (r_wreg[k] == src_reg[i*REGW +: REGW])) begin
          w_found[i] = 1'b1;
          if (k >= (r_load[k] ? LOAD_READY : ALU_READY)) begin
            fwd_sel[i*SELW +: SELW] = SELW'(k);
          end else begin
            w_op_stall[i] = 1'b1;
          end
        end
      end
    end
    stall = |w_op_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      r_valid[1] <= issue_valid && !stall && !flush;
      r_we[1]    <= issue_we;
      r_load[1]  <= issue_load;
      r_wreg[1]  <= issue_wreg;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_load[k]  <= r_load[k-1];
        r_wreg[k]  <= r_wreg[k-1];
      end
      if (stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard and forwarding tracker for the in-order pipeline. It holds a shift chain of pending register writes, one entry per post-decode stage (stage 1 = E, stage 2 = M, …, stage DEPTH = W). Each cycle it tells decode, per source operand, whether to stall or which stage to forward from. It replaces fixed E/M/W compare logic with depth-, width- and port-count-generic logic, and adds an external hold, a flush and a stall-cycle performance counter.

## Interface
- DEPTH, 3, number of tracked post-decode stages (≥2)
- REGW, 5, register index width
- NSRC, 2, number of decode source operands
- ALU_READY, 2, first stage (1..DEPTH) whose non-load result is forwardable
- LOAD_READY, 3, first stage (ALU_READY..DEPTH) whose load result is forwardable
- SELW, $clog2(DEPTH+1), forward-select width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode holds a real instruction
- issue_we  in  1  decode instruction writes a register
- issue_load  in  1  decode instruction is a load
- issue_wreg  in  REGW  destination register of decode instruction
- src_reg  in  NSRC*REGW  source register per operand, operand i at [i*REGW +: REGW]
- src_used  in  NSRC  operand i is actually read
- flush  in  1  insert bubble into stage 1 this cycle (decode instruction killed)
- hold  in  1  freeze the whole chain (external wait, e.g. memory)
- stall  out  1  decode must not advance
- fwd_sel  out  NSRC*SELW  per operand: 0 = regfile, k = forward from stage k
- stall_cnt  out  32  count of cycles with stall=1 and hold=0

## Operation
- Entry per stage k: valid, we, load, wreg. Only valid && we && wreg≠0 entries are "pending".
- Match for operand i: src_used[i], src_reg≠0, pending entry with wreg==src_reg. The youngest matching stage (smallest k) wins; older matches are ignored.
- Ready: the winning entry is ready if k ≥ (load ? LOAD_READY : ALU_READY).
- Per operand: no match → fwd_sel=0; match ready → fwd_sel=k; match not ready → operand stalls and fwd_sel=0.
- stall = OR of operand stalls. Combinational from the current chain state and inputs.
- Chain update when hold=0:
  - Stage 1 loads the decode instruction if issue_valid && !stall && !flush, else a bubble (valid=0).
  - Stage k loads stage k−1 for k=2..DEPTH.
  - The stage DEPTH entry retires; its value is in the regfile afterward.
- hold=1: all entries keep their value. stall and fwd_sel are still computed from the held state. stall_cnt does not increment.
- flush and stall together: bubble inserted, flush dominates, stall_cnt still increments.
- stall_cnt wraps 0xFFFFFFFF→0.

## Timing
- Reset: all valid=0, stall_cnt=0. Hence stall=0 and fwd_sel=0 in the first cycle after reset.
- Reset mid-operation discards all pending entries. No stall is carried over.
- Issue at cycle t becomes stage 1 at t+1 and stage k at t+k. It retires after t+DEPTH.
- Zero-latency outputs: stall and fwd_sel are valid in the same cycle as src_* inputs. No registered outputs except stall_cnt, which updates at the edge after a counted cycle.
- With defaults:
  - Dependent ALU op immediately after its producer stalls 1 cycle, then forwards from 2.
  - Dependent op after a load stalls 2 cycles, then forwards from 3.
- Parameter legality (1 ≤ ALU_READY ≤ LOAD_READY ≤ DEPTH) is checked at elaboration. An illegal setting is a fatal error.

## Test plan
- Reset, then idle with src_used=2'b11, src_reg={8,9} → stall=0, fwd_sel=0, stall_cnt=0.
- Issue ALU write r8, then decode reads r8 on operand 0:
  - First cycle: stall=1.
  - Next cycle: stall=0, fwd_sel[0]=2.
  - Cycle after: fwd_sel[0]=3.
  - Then: fwd_sel[0]=0.
  - stall_cnt=1.
- Issue load r8, then dependent reads r8 → stall=1 for 2 cycles, then fwd_sel[0]=3, stall_cnt=2. Repeat with DEPTH=5, LOAD_READY=4: 3 stall cycles, then fwd_sel[0]=4.
- Younger wins: ALU write r9 at stage 3 and ALU write r9 at stage 2, operand 1 reads r9 → fwd_sel[1]=2. Writes to r0 and unused operands never stall.
- Load r8 in stage 1 with hold=1 for 4 cycles → stall stays 1, stall_cnt unchanged, chain frozen. On release, the sequence completes as in the load case.
- flush=1 while a dependent op stalls → stage 1 bubble. rst=1 with a load pending → next cycle stall=0, fwd_sel=0, stall_cnt=0.
